// File: rtl/kv_filter_table_pkg.sv
// Shared definitions for the key-value filter table: sizes, op/status codes,
// request flag bit positions, FSM states, the table entry layout and the index hash.
package kv_filter_table_pkg;

  localparam int KEY_SIZE     = 96;
  localparam int INDEX_W      = 10;
  localparam int TS_W         = 8;
  localparam int DEF_TICK_DIV = 156;
  localparam int DEF_TIMEOUT  = 200;
  localparam int TABLE_DEPTH  = 2 ** INDEX_W;

  // Request op codes carried in in_flag[2:1]
  localparam logic [1:0] OP_SUSPECT = 2'b01;
  localparam logic [1:0] OP_CHECK   = 2'b10;

  // Entry / reply status codes
  localparam logic [1:0] STATUS_NONE     = 2'b00;
  localparam logic [1:0] STATUS_SUSPECT  = 2'b01;
  localparam logic [1:0] STATUS_ARREST   = 2'b10;
  localparam logic [1:0] STATUS_FILTERED = 2'b11;

  // Request flag bit positions
  localparam int FLAG_REQ   = 0;
  localparam int FLAG_OP_LO = 1;
  localparam int FLAG_OP_HI = 2;
  localparam int FLAG_RSVD  = 3;

  // Table maintenance FSM states
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef struct packed {
    logic                valid;
    logic [KEY_SIZE-1:0] tag;
    logic [1:0]          status;
    logic [TS_W-1:0]     ts;
  } kv_entry_t;

  localparam int ENTRY_W = $bits(kv_entry_t);

  // XOR-fold the key: key bit i lands on index bit (i mod INDEX_W)
  function automatic logic [INDEX_W-1:0] kv_hash(input logic [KEY_SIZE-1:0] key);
    logic [INDEX_W-1:0] h;
    h = '0;
    for (int i = 0; i < KEY_SIZE; i++) begin
      h[i % INDEX_W] = h[i % INDEX_W] ^ key[i];
    end
    return h;
  endfunction

endpackage

// File: rtl/kv_filter_table_ram.sv
// Simple dual-port table storage: one write port, one registered read port.
// Read-during-write to the same address returns the old contents; the top
// module bypasses around that case.
module kv_table_ram
  import kv_filter_table_pkg::*;
#(
  parameter int ADDR_W = INDEX_W,
  parameter int DATA_W = ENTRY_W
) (
  input  logic              clk156,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port
  always_ff @(posedge clk156) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Synchronous read port, one cycle of latency
  always_ff @(posedge clk156) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/kv_filter_table.sv
// Key-value status store: SUSPECT inserts from DNS responses, CHECK promotes
// SUSPECT -> ARREST -> FILTERED. Three-stage pipeline (capture, RAM read,
// decide/write-back), one request per cycle, replies exactly 3 cycles later.
module kv_filter_table
  import kv_filter_table_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                clk156,
  input  logic                eth_rst_n,
  input  logic [KEY_SIZE-1:0] in_key,
  input  logic [3:0]          in_flag,
  input  logic                in_valid,
  output logic                out_valid,
  output logic [3:0]          out_flag,
  output logic                busy,
  output logic [15:0]         stat_hits
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [1:0]          rst_sync;
  logic                rst_n;
  logic [0:0]          state;
  logic [INDEX_W-1:0]  clr_idx;
  logic [TICK_W-1:0]   tick_cnt;
  logic [TS_W-1:0]     now_ts;
  logic                flag_unused;

  logic                s0_valid, s0_look;
  logic [KEY_SIZE-1:0] s0_key;
  logic [1:0]          s0_op;
  logic [INDEX_W-1:0]  s0_idx;
  logic                s1_valid, s1_look;
  logic [KEY_SIZE-1:0] s1_key;
  logic [1:0]          s1_op;
  logic [INDEX_W-1:0]  s1_idx;

  kv_entry_t           rd_entry, cur, dec_entry, wr_data, byp_data;
  logic                byp_valid;
  logic [INDEX_W-1:0]  byp_idx;
  logic [TS_W-1:0]     age;
  logic                hit, dec_wr, dec_promote, wr_en;
  logic [3:0]          dec_flag;
  logic [INDEX_W-1:0]  wr_addr;

  assign flag_unused = in_flag[FLAG_RSVD];

  // Reset synchronizer: asserts immediately, releases two clocks after eth_rst_n rises
  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) rst_sync <= 2'b00;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Post-reset table clear: walk every index once, then enter RUN
  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_INIT;
      clr_idx <= '0;
    end else if (state == ST_INIT) begin
      clr_idx <= clr_idx + 1'b1;
      if (clr_idx == INDEX_W'(TABLE_DEPTH - 1)) state <= ST_RUN;
    end
  end
  assign busy = (state == ST_INIT);

  // Microsecond timestamp: divide clk156 down to ticks, now_ts wraps freely
  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      now_ts   <= '0;
    end else if (tick_cnt == TICK_W'(TICK_DIV - 1)) begin
      tick_cnt <= '0;
      now_ts   <= now_ts + 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // S0/S1: capture request and hash, then carry it alongside the RAM read
  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid <= 1'b0; s0_look <= 1'b0; s0_key <= '0; s0_op <= '0; s0_idx <= '0;
      s1_valid <= 1'b0; s1_look <= 1'b0; s1_key <= '0; s1_op <= '0; s1_idx <= '0;
    end else begin
      s0_valid <= in_valid;
      s0_look  <= in_valid && in_flag[FLAG_REQ] && (state == ST_RUN);
      s0_key   <= in_key;
      s0_op    <= in_flag[FLAG_OP_HI:FLAG_OP_LO];
      s0_idx   <= kv_hash(in_key);
      s1_valid <= s0_valid;
      s1_look  <= s0_look;
      s1_key   <= s0_key;
      s1_op    <= s0_op;
      s1_idx   <= s0_idx;
    end
  end

  kv_table_ram u_ram (
    .clk156  (clk156),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (s0_idx),
    .rd_data (rd_entry)
  );

  // Remember the write that coincided with the current RAM read; the RAM returned stale data for it
  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) begin
      byp_valid <= 1'b0;
      byp_idx   <= '0;
      byp_data  <= '0;
    end else begin
      byp_valid <= wr_en;
      byp_idx   <= wr_addr;
      byp_data  <= wr_data;
    end
  end

  // S2 decision: pick the freshest entry, evaluate hit/age, choose reply and write-back
  always_comb begin
    cur         = (byp_valid && (byp_idx == s1_idx)) ? byp_data : rd_entry;
    age         = now_ts - cur.ts;
    hit         = cur.valid && (cur.tag == s1_key) &&
                  !((cur.status == STATUS_SUSPECT) && (age >= TS_W'(TIMEOUT)));
    dec_flag    = {1'b0, STATUS_NONE, 1'b0};
    dec_wr      = 1'b0;
    dec_promote = 1'b0;
    dec_entry   = cur;
    if (s1_look) begin
      case (s1_op)
        OP_SUSPECT: begin
          if (!hit) begin
            dec_wr           = 1'b1;
            dec_entry.valid  = 1'b1;
            dec_entry.tag    = s1_key;
            dec_entry.status = STATUS_SUSPECT;
            dec_entry.ts     = now_ts;
            dec_flag         = {1'b0, STATUS_SUSPECT, 1'b0};
          end else if (cur.status == STATUS_SUSPECT) begin
            dec_wr       = 1'b1;
            dec_entry.ts = now_ts;
            dec_flag     = {1'b0, STATUS_SUSPECT, 1'b1};
          end else begin
            dec_flag = {1'b0, cur.status, 1'b1};
          end
        end
        OP_CHECK: begin
          if (hit) begin
            case (cur.status)
              STATUS_SUSPECT: begin
                dec_wr           = 1'b1;
                dec_promote      = 1'b1;
                dec_entry.status = STATUS_ARREST;
                dec_flag         = {1'b0, STATUS_ARREST, 1'b1};
              end
              STATUS_ARREST: begin
                dec_wr           = 1'b1;
                dec_entry.status = STATUS_FILTERED;
                dec_flag         = {1'b0, STATUS_FILTERED, 1'b1};
              end
              default: dec_flag = {1'b0, STATUS_FILTERED, 1'b1};
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  // Write port owner: the clear walk during INIT, the pipeline write-back in RUN
  always_comb begin
    if (state == ST_INIT) begin
      wr_en   = 1'b1;
      wr_addr = clr_idx;
      wr_data = '0;
    end else begin
      wr_en   = dec_wr;
      wr_addr = s1_idx;
      wr_data = dec_entry;
    end
  end

  // Reply register and saturating promotion counter
  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_flag  <= 4'b0000;
      stat_hits <= 16'h0000;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) out_flag <= dec_flag;
      if (dec_promote && (stat_hits != 16'hFFFF)) stat_hits <= stat_hits + 16'h0001;
    end
  end

endmodule

// File: tb/tb_kv_filter_table.sv
// Self-checking bench for kv_filter_table: expected replies are queued when a
// request is driven and matched, with arrival cycle, against captured replies.
module tb_kv_filter_table;
  import kv_filter_table_pkg::*;

  localparam int TICK_DIV   = 156;
  localparam int TIMEOUT    = 200;
  localparam int LAT        = 3;
  localparam int INIT_CYC   = 1024 + 2;   // clear walk plus two-flop reset release
  localparam logic [3:0] F_SUS = 4'b0011;
  localparam logic [3:0] F_CHK = 4'b0101;

  typedef struct {
    int         cyc;
    logic [3:0] flag;
  } rep_t;

  logic                clk156;
  logic                eth_rst_n;
  logic [KEY_SIZE-1:0] in_key;
  logic [3:0]          in_flag;
  logic                in_valid;
  logic                out_valid;
  logic [3:0]          out_flag;
  logic                busy;
  logic [15:0]         stat_hits;

  int   cyc;
  int   tests_run;
  int   tests_failed;
  rep_t exp_q[$];
  rep_t recv_q[$];

  kv_filter_table #(.TICK_DIV(TICK_DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk156    (clk156),
    .eth_rst_n (eth_rst_n),
    .in_key    (in_key),
    .in_flag   (in_flag),
    .in_valid  (in_valid),
    .out_valid (out_valid),
    .out_flag  (out_flag),
    .busy      (busy),
    .stat_hits (stat_hits)
  );

  initial clk156 = 1'b0;
  always #3 clk156 = ~clk156;

  always @(posedge clk156) cyc <= cyc + 1;

  // Passive reply capture on the falling edge
  always @(negedge clk156) begin
    rep_t r;
    if (out_valid === 1'b1) begin
      r.cyc  = cyc;
      r.flag = out_flag;
      recv_q.push_back(r);
    end
  end

  task automatic send(input logic [KEY_SIZE-1:0] key, input logic [3:0] flag,
                      input logic [3:0] want, input bit track);
    rep_t e;
    @(posedge clk156); #1;
    in_key   = key;
    in_flag  = flag;
    in_valid = 1'b1;
    if (track) begin
      e.cyc  = cyc + LAT;
      e.flag = want;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk156); #1;
      in_valid = 1'b0;
      in_flag  = 4'b0000;
    end
  endtask

  task automatic test_reset();
    int n;
    eth_rst_n = 1'b0;
    in_valid  = 1'b0;
    in_flag   = 4'b0000;
    in_key    = '0;
    repeat (3) @(posedge clk156);
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_flag !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_reply: out_valid=%b out_flag=%b, required 0/0000", out_valid, out_flag);
    end
    tests_run++;
    if (stat_hits !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_stat: stat_hits=%h, required 0000", stat_hits);
    end
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_busy: busy=%b, required 1", busy);
    end
    eth_rst_n = 1'b1;
    n = 0;
    while (n < 3000) begin
      @(posedge clk156); #1;
      n++;
      if (busy === 1'b0) break;
    end
    tests_run++;
    if (n != INIT_CYC) begin
      tests_failed++;
      $display("[TB] FAIL init_length: busy fell after %0d cycles, required %0d", n, INIT_CYC);
    end
  endtask

  task automatic test_init_requests();
    logic [KEY_SIZE-1:0] kx;
    rep_t e, r;
    kx = 96'h0102_0304_0506_0708_090A_0000;
    @(posedge clk156); #1;
    eth_rst_n = 1'b0;
    repeat (2) @(posedge clk156);
    #1 eth_rst_n = 1'b1;
    idle(10);
    send(kx, F_SUS, 4'b0000, 1'b1);
    send(kx, F_CHK, 4'b0000, 1'b1);
    idle(1);
    repeat (2000) begin
      @(posedge clk156);
      if (busy === 1'b0) break;
    end
    idle(2);
    send(kx, F_CHK, 4'b0000, 1'b1);
    idle(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (recv_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL init_reply: no reply, required %b at cycle %0d", e.flag, e.cyc);
      end else begin
        r = recv_q.pop_front();
        if (r.flag !== e.flag || r.cyc != e.cyc) begin
          tests_failed++;
          $display("[TB] FAIL init_reply: got %b at cycle %0d, required %b at cycle %0d", r.flag, r.cyc, e.flag, e.cyc);
        end
      end
    end
  endtask

  task automatic test_basic();
    logic [KEY_SIZE-1:0] k, u;
    rep_t e, r;
    k = 96'hC0A8_0001_C0A8_0002_3039_0000;
    u = 96'hDEAD_BEEF_0BAD_F00D_1234_0000;
    send(k, F_SUS,   4'b0010, 1'b1); idle(4);
    send(k, F_CHK,   4'b0101, 1'b1); idle(4);
    send(u, F_CHK,   4'b0000, 1'b1); idle(4);
    send(k, F_CHK,   4'b0111, 1'b1); idle(4);
    send(k, F_CHK,   4'b0111, 1'b1); idle(4);
    send(k, F_SUS,   4'b0111, 1'b1); idle(4);
    send(k, 4'b0100, 4'b0000, 1'b1); idle(4);
    send(k, 4'b0111, 4'b0000, 1'b1); idle(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (recv_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL basic_reply: no reply, required %b at cycle %0d", e.flag, e.cyc);
      end else begin
        r = recv_q.pop_front();
        if (r.flag !== e.flag || r.cyc != e.cyc) begin
          tests_failed++;
          $display("[TB] FAIL basic_reply: got %b at cycle %0d, required %b at cycle %0d", r.flag, r.cyc, e.flag, e.cyc);
        end
      end
    end
    tests_run++;
    if (stat_hits !== 16'd1) begin
      tests_failed++;
      $display("[TB] FAIL basic_stat: stat_hits=%0d, required 1", stat_hits);
    end
  endtask

  task automatic test_back_to_back();
    logic [KEY_SIZE-1:0] k2, k3;
    rep_t e, r;
    k2 = 96'hC0A8_0001_C0A8_0003_0035_0000;
    k3 = 96'hC0A8_0001_C0A8_0004_0035_0000;
    send(k2, F_SUS, 4'b0010, 1'b1);
    send(k2, F_CHK, 4'b0101, 1'b1);
    send(k2, F_CHK, 4'b0111, 1'b1);
    send(k2, F_SUS, 4'b0111, 1'b1);
    send(k3, F_SUS, 4'b0010, 1'b1);
    send(k3, F_SUS, 4'b0011, 1'b1);
    send(k3, F_CHK, 4'b0101, 1'b1);
    idle(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (recv_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL b2b_reply: no reply, required %b at cycle %0d", e.flag, e.cyc);
      end else begin
        r = recv_q.pop_front();
        if (r.flag !== e.flag || r.cyc != e.cyc) begin
          tests_failed++;
          $display("[TB] FAIL b2b_reply: got %b at cycle %0d, required %b at cycle %0d", r.flag, r.cyc, e.flag, e.cyc);
        end
      end
    end
    tests_run++;
    if (recv_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_extra: %0d unexpected replies, required 0", recv_q.size());
      recv_q.delete();
    end
    tests_run++;
    if (stat_hits !== 16'd3) begin
      tests_failed++;
      $display("[TB] FAIL b2b_stat: stat_hits=%0d, required 3", stat_hits);
    end
  endtask

  task automatic test_aging();
    logic [KEY_SIZE-1:0] k4, k5;
    rep_t e, r;
    k4 = 96'h0A00_0001_0A00_0002_0035_0000;
    k5 = k4 ^ 96'h1;
    send(k4, F_SUS, 4'b0010, 1'b1);
    send(k5, F_SUS, 4'b0010, 1'b1);
    idle((TIMEOUT - 2) * TICK_DIV);
    send(k5, F_CHK, 4'b0101, 1'b1);
    idle(3 * TICK_DIV);
    send(k4, F_CHK, 4'b0000, 1'b1);
    idle(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (recv_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL aging_reply: no reply, required %b at cycle %0d", e.flag, e.cyc);
      end else begin
        r = recv_q.pop_front();
        if (r.flag !== e.flag || r.cyc != e.cyc) begin
          tests_failed++;
          $display("[TB] FAIL aging_reply: got %b at cycle %0d, required %b at cycle %0d", r.flag, r.cyc, e.flag, e.cyc);
        end
      end
    end
  endtask

  task automatic test_collision();
    logic [KEY_SIZE-1:0] ka, kb;
    rep_t e, r;
    // Key bits 0 and 10 fold onto the same index bit, so flipping both keeps the index
    ka = 96'h1111_2222_3333_4444_5555_0000;
    kb = ka ^ 96'h401;
    send(ka, F_SUS, 4'b0010, 1'b1);
    send(kb, F_SUS, 4'b0010, 1'b1);
    send(ka, F_CHK, 4'b0000, 1'b1);
    send(kb, F_CHK, 4'b0101, 1'b1);
    idle(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (recv_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL collide_reply: no reply, required %b at cycle %0d", e.flag, e.cyc);
      end else begin
        r = recv_q.pop_front();
        if (r.flag !== e.flag || r.cyc != e.cyc) begin
          tests_failed++;
          $display("[TB] FAIL collide_reply: got %b at cycle %0d, required %b at cycle %0d", r.flag, r.cyc, e.flag, e.cyc);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [KEY_SIZE-1:0] ka, kb;
    int n;
    rep_t e, r;
    ka = 96'h1111_2222_3333_4444_5555_0000;
    kb = ka ^ 96'h401;
    send(ka, F_CHK, 4'b0000, 1'b0);
    send(kb, F_CHK, 4'b0000, 1'b0);
    send(kb, F_SUS, 4'b0000, 1'b0);
    #2;
    eth_rst_n = 1'b0;
    in_valid  = 1'b0;
    repeat (4) @(negedge clk156);
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || stat_hits !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL midreset_hold: out_valid=%b busy=%b stat_hits=%h, required 0/1/0000", out_valid, busy, stat_hits);
    end
    @(posedge clk156); #1;
    eth_rst_n = 1'b1;
    n = 0;
    while (n < 3000) begin
      @(posedge clk156); #1;
      n++;
      if (busy === 1'b0) break;
    end
    tests_run++;
    if (n != INIT_CYC) begin
      tests_failed++;
      $display("[TB] FAIL midreset_init: busy fell after %0d cycles, required %0d", n, INIT_CYC);
    end
    tests_run++;
    if (recv_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_stray: %0d replies seen, required 0", recv_q.size());
      recv_q.delete();
    end
    send(ka, F_CHK, 4'b0000, 1'b1);
    send(kb, F_CHK, 4'b0000, 1'b1);
    idle(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (recv_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL midreset_reply: no reply, required %b at cycle %0d", e.flag, e.cyc);
      end else begin
        r = recv_q.pop_front();
        if (r.flag !== e.flag || r.cyc != e.cyc) begin
          tests_failed++;
          $display("[TB] FAIL midreset_reply: got %b at cycle %0d, required %b at cycle %0d", r.flag, r.cyc, e.flag, e.cyc);
        end
      end
    end
  endtask

  initial begin
    cyc          = 0;
    tests_run    = 0;
    tests_failed = 0;
    eth_rst_n    = 1'b0;
    in_valid     = 1'b0;
    in_flag      = 4'b0000;
    in_key       = '0;
    test_reset();
    test_init_requests();
    test_basic();
    test_back_to_back();
    test_aging();
    test_collision();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
